// File: rtl/event_pulse_out.sv
// -----------------------------------------------------------------------------
// event_pulse_out
//
// Turns single-clk event requests from core logic into pulses on one physical
// pin (LED, buzzer, sensor trigger) with exact high time and a guaranteed low
// gap. Requests arriving while a pulse is in progress are queued in a small
// saturating counter and replayed in order.
//
// Ports
//   clk         in   1       system clock
//   reset       in   1       asynchronous, active-low reset
//   i_pulse     in   1       event request, one-clk pulse, sampled every edge
//   o_out       out  1       registered physical output pulse
//   o_busy      out  1       1 while a pulse or its low gap is in progress
//   o_pend      out  PEND_W  events queued but not yet started
//   o_overflow  out  1       one-clk pulse: request dropped, queue full
// -----------------------------------------------------------------------------
module event_pulse_out #(
    parameter int TICK_DIV   = 100_000,
    parameter int HIGH_TICKS = 10,
    parameter int LOW_TICKS  = 10,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pulse,
    output logic              o_out,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pend,
    output logic              o_overflow
);

    localparam int PRESC_W   = $clog2(TICK_DIV + 1);
    localparam int MAX_TICKS = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  HIGH_LAST  = TICK_W'(HIGH_TICKS - 1);
    localparam logic [TICK_W-1:0]  LOW_LAST   = TICK_W'(LOW_TICKS - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0]  PEND_ZERO  = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0]  PEND_ONE   = PEND_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_r;
    logic [PRESC_W-1:0]  presc_r;
    logic [TICK_W-1:0]   tick_cnt_r;

    logic                tick_s;
    logic                start_s;
    logic [PEND_W-1:0]   pend_nxt_s;
    logic                ovf_nxt_s;

    // Tick strobe and queue-pop decode; a pulse starts only from the registered count.
    always_comb begin
        tick_s  = (presc_r == PRESC_LAST);
        start_s = (state_r == ST_IDLE) && (o_pend != PEND_ZERO);
    end

    // Next pending count: push on request, pop on pulse start, saturate when full.
    always_comb begin
        pend_nxt_s = o_pend;
        ovf_nxt_s  = 1'b0;
        if (i_pulse && !start_s) begin
            if (o_pend == PEND_MAX) begin
                ovf_nxt_s = 1'b1;
            end else begin
                pend_nxt_s = o_pend + PEND_ONE;
            end
        end else if (!i_pulse && start_s) begin
            pend_nxt_s = o_pend - PEND_ONE;
        end else begin
            // push and pop in the same edge cancel out
            pend_nxt_s = o_pend;
        end
    end

    // Pending counter and overflow strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_pend     <= PEND_ZERO;
            o_overflow <= 1'b0;
        end else begin
            o_pend     <= pend_nxt_s;
            o_overflow <= ovf_nxt_s;
        end
    end

    // Pulse FSM with prescaler and tick counter; both counters restart on every
    // state change so high and gap durations are exact multiples of TICK_DIV.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            presc_r    <= {PRESC_W{1'b0}};
            tick_cnt_r <= {TICK_W{1'b0}};
            o_out      <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_r    <= {PRESC_W{1'b0}};
                    tick_cnt_r <= {TICK_W{1'b0}};
                    if (start_s) begin
                        state_r <= ST_HIGH;
                        o_out   <= 1'b1;
                        o_busy  <= 1'b1;
                    end else begin
                        o_out  <= 1'b0;
                        o_busy <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (tick_s && (tick_cnt_r == HIGH_LAST)) begin
                        state_r    <= ST_GAP;
                        o_out      <= 1'b0;
                        presc_r    <= {PRESC_W{1'b0}};
                        tick_cnt_r <= {TICK_W{1'b0}};
                    end else if (tick_s) begin
                        presc_r    <= {PRESC_W{1'b0}};
                        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                    end else begin
                        presc_r <= presc_r + PRESC_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tick_s && (tick_cnt_r == LOW_LAST)) begin
                        state_r    <= ST_IDLE;
                        o_busy     <= 1'b0;
                        presc_r    <= {PRESC_W{1'b0}};
                        tick_cnt_r <= {TICK_W{1'b0}};
                    end else if (tick_s) begin
                        presc_r    <= {PRESC_W{1'b0}};
                        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                    end else begin
                        presc_r <= presc_r + PRESC_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    presc_r    <= {PRESC_W{1'b0}};
                    tick_cnt_r <= {TICK_W{1'b0}};
                    o_out      <= 1'b0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_pulse_out.sv
// -----------------------------------------------------------------------------
// tb_event_pulse_out
//
// Directed scenarios followed by randomized request traffic. Expected outputs
// come from a window-countdown model: a started event owns a busy window of
// (HIGH+LOW)*TICK_DIV clks, the pin is high during its first HIGH*TICK_DIV clks,
// and a new event may start only on an edge where no window is active.
// -----------------------------------------------------------------------------
module tb_event_pulse_out;

    localparam int TICK_DIV   = 2;
    localparam int HIGH_TICKS = 3;
    localparam int LOW_TICKS  = 2;
    localparam int PEND_W     = 2;

    localparam int HIGH_CLKS = HIGH_TICKS * TICK_DIV;
    localparam int LOW_CLKS  = LOW_TICKS * TICK_DIV;
    localparam int BUSY_CLKS = HIGH_CLKS + LOW_CLKS;
    localparam int PEND_MAX  = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_pulse = 1'b0;
    logic              o_out;
    logic              o_busy;
    logic [PEND_W-1:0] o_pend;
    logic              o_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    int m_busy_left = 0;
    int m_pend = 0;
    int m_ovf = 0;

    // observed-pulse bookkeeping
    int cyc = 0;
    int hi_run = 0;
    int last_rise = -1;
    int rise_count = 0;
    bit prev_out = 1'b0;

    event_pulse_out #(
        .TICK_DIV  (TICK_DIV),
        .HIGH_TICKS(HIGH_TICKS),
        .LOW_TICKS (LOW_TICKS),
        .PEND_W    (PEND_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_pulse   (i_pulse),
        .o_out     (o_out),
        .o_busy    (o_busy),
        .o_pend    (o_pend),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_busy_left = 0;
        m_pend = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge(input logic p);
        bit start;
        start = (m_busy_left == 0) && (m_pend > 0);
        if (m_busy_left > 0) m_busy_left--;
        else if (start) m_busy_left = BUSY_CLKS;
        m_ovf = 0;
        if (p && !start) begin
            if (m_pend == PEND_MAX) m_ovf = 1;
            else m_pend++;
        end else if (!p && start) begin
            m_pend--;
        end
    endtask

    task automatic check_all();
        check_eq("o_out", int'(o_out), (m_busy_left > LOW_CLKS) ? 1 : 0);
        check_eq("o_busy", int'(o_busy), (m_busy_left != 0) ? 1 : 0);
        check_eq("o_pend", int'(o_pend), m_pend);
        check_eq("o_overflow", int'(o_overflow), m_ovf);
    endtask

    task automatic track_pulse();
        if (o_out) begin
            if (!prev_out) begin
                if (last_rise >= 0)
                    check_eq("rise_spacing_ok", ((cyc - last_rise) >= BUSY_CLKS + 1) ? 1 : 0, 1);
                last_rise = cyc;
                rise_count++;
            end
            hi_run++;
        end else begin
            if (prev_out) check_eq("high_width", hi_run, HIGH_CLKS);
            hi_run = 0;
        end
        prev_out = o_out;
    endtask

    task automatic forget_pulse();
        prev_out = 1'b0;
        hi_run = 0;
        last_rise = -1;
    endtask

    // One clock: drive request, model the edge, then sample just after it.
    task automatic step(input logic p);
        i_pulse = p;
        @(posedge clk);
        if (!reset) model_clear();
        else model_edge(p);
        #1;
        cyc++;
        check_all();
        track_pulse();
    endtask

    // Asynchronous reset between edges, held for some clocks, then released.
    task automatic async_reset(input int hold_cycles);
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        check_all();
        forget_pulse();
        repeat (hold_cycles) step(1'b0);
        reset = 1'b1;
    endtask

    task automatic idle_run(input int n);
        repeat (n) step(1'b0);
    endtask

    initial begin
        int rc0;
        int prob;

        // reset held: toggling requests must leave everything at zero
        #1;
        check_all();
        for (int i = 0; i < 6; i++) step(i[0]);
        reset = 1'b1;
        idle_run(2);

        // single event
        rc0 = rise_count;
        step(1'b1);
        check_eq("single_pend_after_e0", int'(o_pend), 1);
        idle_run(16);
        check_eq("single_pulse_count", rise_count - rc0, 1);

        // three back-to-back requests, rises exactly 11 clks apart
        rc0 = rise_count;
        step(1'b1); step(1'b1); step(1'b1);
        check_eq("triple_pend", int'(o_pend), 2);
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            if (o_out && !o_busy) check_eq("out_implies_busy", 0, 1);
        end
        check_eq("triple_pulse_count", rise_count - rc0, 3);

        // five requests saturate the queue and drop one
        rc0 = rise_count;
        for (int i = 0; i < 5; i++) step(1'b1);
        check_eq("sat_overflow", int'(o_overflow), 1);
        check_eq("sat_pend", int'(o_pend), PEND_MAX);
        idle_run(50);
        check_eq("sat_pulse_count", rise_count - rc0, 4);

        // reset during the first high phase discards everything
        step(1'b1); step(1'b1);
        idle_run(2);
        async_reset(3);
        rc0 = rise_count;
        idle_run(30);
        check_eq("post_reset_pulse_count", rise_count - rc0, 0);

        // request arriving in mid-gap does not stretch the gap
        rc0 = rise_count;
        step(1'b1);
        idle_run(8);
        step(1'b1);
        idle_run(20);
        check_eq("midgap_pulse_count", rise_count - rc0, 2);

        // randomized traffic with occasional mid-run resets
        for (int seg = 0; seg < 40; seg++) begin
            prob = $urandom_range(0, 60);
            for (int i = 0; i < 60; i++) step(($urandom_range(0, 99) < prob) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 3) == 0) async_reset($urandom_range(1, 3));
        end
        idle_run(60);
        check_eq("drain_idle", int'(o_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
